// File: rtl/ram_burst_slave.sv
// On-chip data RAM bus slave with byte-strobed single-beat writes, incrementing
// read bursts and a configurable read latency. Each read beat is range-checked
// on its own; out-of-range beats return zero data with an error flag. Out-of-range
// writes are dropped and reported with a one-cycle pulse.
module ram_burst_slave #(
   parameter int unsigned DW     = 16,
   parameter int unsigned AW     = 16,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned LENW   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [AW-1:0]     req_addr_i,
   input  logic [LENW-1:0]   req_len_i,
   input  logic [DW-1:0]     req_wdata_i,
   input  logic [DW/8-1:0]   req_strb_i,
   output logic              rsp_valid_o,
   output logic [DW-1:0]     rsp_rdata_o,
   output logic              rsp_last_o,
   output logic              rsp_err_o,
   output logic              wr_err_o
);

   localparam int unsigned NB   = DW / 8;
   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain
   } state_e;

   // Control state
   state_e          state_q;
   logic            ready_q;
   logic [AW-1:0]   addr_q;
   logic [LENW-1:0] len_q;
   logic [LENW-1:0] beat_q;
   logic            wr_err_q;

   // Storage; deliberately never reset so contents survive rst_n
   logic [DW-1:0]   mem_q [DEPTH];

   // Read pipeline: stage 0 is the RAM read, the rest are plain delay stages
   logic            pipe_vld_q  [RD_LAT];
   logic            pipe_last_q [RD_LAT];
   logic            pipe_err_q  [RD_LAT];
   logic [DW-1:0]   pipe_data_q [RD_LAT];

   // Next values entering stage 0
   logic            s0_vld_d;
   logic            s0_last_d;
   logic            s0_err_d;
   logic [DW-1:0]   s0_data_d;

   logic            accept;
   logic            mem_we;
   logic            req_in_range;
   logic            beat_in_range;
   logic            issue;
   logic            out_last;
   logic [IdxW-1:0] req_idx;
   logic [IdxW-1:0] beat_idx;

   // Widen before comparing so DEPTH == 2^AW is handled without overflow
   function automatic logic in_range(input logic [AW-1:0] a);
      return 64'(a) < 64'(DEPTH);
   endfunction

   assign accept        = req_valid_i & ready_q;
   assign req_in_range  = in_range(req_addr_i);
   assign beat_in_range = in_range(addr_q);
   assign req_idx       = req_addr_i[IdxW-1:0];
   assign beat_idx      = addr_q[IdxW-1:0];
   // ready is only high in StIdle, so a write can never collide with a read issue
   assign mem_we        = accept & req_write_i & req_in_range;
   assign issue         = (state_q == StIssue);
   assign out_last      = pipe_vld_q[RD_LAT-1] & pipe_last_q[RD_LAT-1];

   // Request FSM: accepts requests, walks the burst address, tracks drain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         ready_q  <= 1'b1;
         addr_q   <= '0;
         len_q    <= '0;
         beat_q   <= '0;
         wr_err_q <= 1'b0;
      end else begin
         wr_err_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  if (req_write_i) begin
                     wr_err_q <= ~req_in_range;
                  end else begin
                     state_q <= StIssue;
                     ready_q <= 1'b0;
                     addr_q  <= req_addr_i;
                     len_q   <= req_len_i;
                     beat_q  <= '0;
                  end
               end
            end
            StIssue: begin
               // Address wraps modulo 2^AW by construction of the register width
               addr_q <= addr_q + 1'b1;
               beat_q <= beat_q + 1'b1;
               if (beat_q == len_q) begin
                  state_q <= StDrain;
               end
            end
            StDrain: begin
               // Last beat on the output now means the pipe is empty after this edge
               if (out_last) begin
                  state_q <= StIdle;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Byte-lane writes; lanes with a clear strobe keep their old contents
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < int'(NB); i++) begin
            if (req_strb_i[i]) begin
               mem_q[req_idx][8*i +: 8] <= req_wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Stage 0 inputs: idle cycles push zeros so outputs read 0 when not valid
   always_comb begin
      s0_vld_d  = issue;
      s0_last_d = issue & (beat_q == len_q);
      s0_err_d  = issue & ~beat_in_range;
      s0_data_d = '0;
      if (issue && beat_in_range) begin
         s0_data_d = mem_q[beat_idx];
      end
   end

   // Read pipeline: RAM read register followed by RD_LAT-1 delay stages
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_vld_q[i]  <= 1'b0;
            pipe_last_q[i] <= 1'b0;
            pipe_err_q[i]  <= 1'b0;
            pipe_data_q[i] <= '0;
         end
      end else begin
         pipe_vld_q[0]  <= s0_vld_d;
         pipe_last_q[0] <= s0_last_d;
         pipe_err_q[0]  <= s0_err_d;
         pipe_data_q[0] <= s0_data_d;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_vld_q[i]  <= pipe_vld_q[i-1];
            pipe_last_q[i] <= pipe_last_q[i-1];
            pipe_err_q[i]  <= pipe_err_q[i-1];
            pipe_data_q[i] <= pipe_data_q[i-1];
         end
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = pipe_vld_q[RD_LAT-1];
   assign rsp_last_o  = pipe_last_q[RD_LAT-1];
   assign rsp_err_o   = pipe_err_q[RD_LAT-1];
   assign rsp_rdata_o = pipe_data_q[RD_LAT-1];
   assign wr_err_o    = wr_err_q;

endmodule

// File: tb/tb_ram_burst_slave.sv
// Directed bench for ram_burst_slave. Three instances share one request bus:
// d0 = DEPTH 1024 / RD_LAT 1, d1 = DEPTH 1024 / RD_LAT 3, d2 = DEPTH 65536 / RD_LAT 1.
// Requests are only issued when all three are ready, so all accept together.
module tb_ram_burst_slave;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_write;
   logic [15:0]       req_addr;
   logic [2:0]        req_len;
   logic [15:0]       req_wdata;
   logic [1:0]        req_strb;
   logic [2:0]        req_ready;
   logic [2:0]        rsp_valid;
   logic [2:0]        rsp_last;
   logic [2:0]        rsp_err;
   logic [2:0]        wr_err;
   logic [2:0][15:0]  rsp_rdata;

   int checks = 0;
   int errors = 0;

   // Bench-side memory image per instance
   logic [15:0] mdl [3][65536];

   ram_burst_slave #(.DW(16), .AW(16), .DEPTH(1024), .RD_LAT(1), .LENW(3)) u_d0 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_len_i(req_len),
      .req_wdata_i(req_wdata), .req_strb_i(req_strb), .rsp_valid_o(rsp_valid[0]),
      .rsp_rdata_o(rsp_rdata[0]), .rsp_last_o(rsp_last[0]), .rsp_err_o(rsp_err[0]),
      .wr_err_o(wr_err[0])
   );

   ram_burst_slave #(.DW(16), .AW(16), .DEPTH(1024), .RD_LAT(3), .LENW(3)) u_d1 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_len_i(req_len),
      .req_wdata_i(req_wdata), .req_strb_i(req_strb), .rsp_valid_o(rsp_valid[1]),
      .rsp_rdata_o(rsp_rdata[1]), .rsp_last_o(rsp_last[1]), .rsp_err_o(rsp_err[1]),
      .wr_err_o(wr_err[1])
   );

   ram_burst_slave #(.DW(16), .AW(16), .DEPTH(65536), .RD_LAT(1), .LENW(3)) u_d2 (
      .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready[2]),
      .req_write_i(req_write), .req_addr_i(req_addr), .req_len_i(req_len),
      .req_wdata_i(req_wdata), .req_strb_i(req_strb), .rsp_valid_o(rsp_valid[2]),
      .rsp_rdata_o(rsp_rdata[2]), .rsp_last_o(rsp_last[2]), .rsp_err_o(rsp_err[2]),
      .wr_err_o(wr_err[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   function automatic int dep(input int d);
      return (d == 2) ? 65536 : 1024;
   endfunction

   function automatic int lat(input int d);
      return (d == 1) ? 3 : 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; waits (bounded) until every instance is ready
   task automatic wait_ready();
      int n = 0;
      while (req_ready !== 3'b111 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(req_ready), 32'(3'b111));
   endtask

   // Single write; returns at the falling edge right after the accept edge
   task automatic wr(input logic [15:0] a, input logic [15:0] wd, input logic [1:0] s);
      logic [2:0] exp_err;
      wait_ready();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = a;
      req_wdata = wd;
      req_strb  = s;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'b0;
      for (int d = 0; d < 3; d++) begin
         if (32'(a) < dep(d)) begin
            exp_err[d] = 1'b0;
            if (s[0]) mdl[d][a][7:0]  = wd[7:0];
            if (s[1]) mdl[d][a][15:8] = wd[15:8];
         end else begin
            exp_err[d] = 1'b1;
         end
      end
      chk($sformatf("wr_err_%h", a), 32'(wr_err), 32'(exp_err));
   endtask

   // Read request; returns at the falling edge right after the accept edge
   task automatic rd_req(input logic [15:0] a, input logic [2:0] len);
      wait_ready();
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = a;
      req_len   = len;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Cycle-by-cycle check of beats and ready for all instances after rd_req
   task automatic check_burst(input string tag, input logic [15:0] a0, input int len);
      logic [18:0] exp;
      logic [15:0] a;
      int          k;
      for (int idx = 0; idx <= len + 5; idx++) begin
         for (int d = 0; d < 3; d++) begin
            k   = idx - lat(d);
            exp = '0;
            if (k >= 0 && k <= len) begin
               a   = a0 + 16'(k);
               exp = {1'b1, (k == len), !(32'(a) < dep(d)),
                      (32'(a) < dep(d)) ? mdl[d][a] : 16'h0000};
            end
            chk($sformatf("%s_d%0d_c%0d", tag, d, idx),
                32'({rsp_valid[d], rsp_last[d], rsp_err[d], rsp_rdata[d]}), 32'(exp));
            chk($sformatf("%s_rdy_d%0d_c%0d", tag, d, idx),
                32'(req_ready[d]), 32'(idx > lat(d) + len));
         end
         @(negedge clk);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_len   = '0;
      req_wdata = '0;
      req_strb  = '0;

      // 1: reset and idle
      repeat (3) @(negedge clk);
      chk("rst_valid_in_reset", 32'(rsp_valid), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'(3'b111));
      chk("rst_valid", 32'(rsp_valid), 32'(0));
      chk("rst_wr_err", 32'(wr_err), 32'(0));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("idle_valid_%0d", i), 32'(rsp_valid), 32'(0));
      end

      // 2: byte strobes merge
      wr(16'h0010, 16'hA5C3, 2'b11);
      wr(16'h0010, 16'h00FF, 2'b01);
      rd_req(16'h0010, 3'd0);
      chk("t2_not_yet", 32'(rsp_valid[0]), 32'(0));
      @(negedge clk);
      chk("t2_beat", 32'({rsp_valid[0], rsp_last[0], rsp_err[0], rsp_rdata[0]}),
          32'({1'b1, 1'b1, 1'b0, 16'hA5FF}));

      // 3: eight-beat burst, checked on all latencies
      for (int i = 0; i < 8; i++) wr(16'h0020 + 16'(i), 16'h1000 + 16'(i), 2'b11);
      rd_req(16'h0020, 3'd7);
      check_burst("t3", 16'h0020, 7);

      // 4: burst crossing the end of a 1024-word array, out-of-range write
      wr(16'h0000, 16'hBEEF, 2'b11);
      wr(16'h03FE, 16'h3FE0, 2'b11);
      wr(16'h03FF, 16'h3FF0, 2'b11);
      wr(16'h0400, 16'h4000, 2'b11);
      wr(16'h0401, 16'h4010, 2'b11);
      rd_req(16'h03FE, 3'd3);
      check_burst("t4", 16'h03FE, 3);
      wr(16'h0400, 16'hDEAD, 2'b11);
      @(negedge clk);
      chk("t4_wr_err_one_cycle", 32'(wr_err), 32'(0));
      rd_req(16'h0000, 3'd0);
      check_burst("t4_addr0", 16'h0000, 0);

      // 5: read right after write, then address wrap
      wr(16'h0005, 16'h1234, 2'b11);
      rd_req(16'h0005, 3'd0);
      chk("t5_not_yet", 32'(rsp_valid[0]), 32'(0));
      @(negedge clk);
      chk("t5_b2b", 32'({rsp_valid[0], rsp_rdata[0]}), 32'({1'b1, 16'h1234}));
      repeat (4) @(negedge clk);
      wr(16'hFFFF, 16'h7777, 2'b11);
      wr(16'h0000, 16'h8888, 2'b11);
      rd_req(16'hFFFF, 3'd1);
      check_burst("t5_wrap", 16'hFFFF, 1);

      // 6: reset in the middle of a burst
      for (int i = 0; i < 8; i++) wr(16'h0040 + 16'(i), 16'h5A00 + 16'(i), 2'b11);
      rd_req(16'h0040, 3'd7);
      repeat (3) @(negedge clk);
      chk("t6_beat2", 32'({rsp_valid[0], rsp_rdata[0]}), 32'({1'b1, 16'h5A02}));
      rst_n = 1'b0;
      #1;
      chk("t6_drop", 32'(rsp_valid), 32'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk($sformatf("t6_quiet_%0d", i), 32'(rsp_valid), 32'(0));
      end
      rd_req(16'h0040, 3'd7);
      check_burst("t6_intact", 16'h0040, 7);
      rd_req(16'h0010, 3'd0);
      @(negedge clk);
      chk("t6_old_data", 32'({rsp_valid[0], rsp_rdata[0]}), 32'({1'b1, 16'hA5FF}));
      repeat (5) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
